// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: opcodes, instruction field positions, op classes, ALU funct codes.
// M-extension funct codes always exist here; decode_comb emits them only under DECODE_M_EXT_EN.
package decode_stage_pkg;

  localparam int ALU_FUNCT_WIDTH = 5;

  typedef enum logic [ALU_FUNCT_WIDTH-1:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
  } alu_funct_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_LSB = 25;
  localparam int SHAMT_LSB  = 20;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
  localparam logic [6:0] FUNCT7_M    = 7'b0000001;

  typedef enum logic [3:0] {
    OC_ILLEGAL = 4'd0,
    OC_OP      = 4'd1,
    OC_OP_IMM  = 4'd2,
    OC_LOAD    = 4'd3,
    OC_STORE   = 4'd4,
    OC_BRANCH  = 4'd5,
    OC_LUI     = 4'd6,
    OC_AUIPC   = 4'd7,
    OC_JAL     = 4'd8,
    OC_JALR    = 4'd9,
    OC_SYSTEM  = 4'd10
  } op_class_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Base integer op for a funct3 when funct7 selects the non-alternate form.
  function automatic alu_funct_e base_funct(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic alu_funct_e m_funct(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return ALU_MUL;
      3'b001:  return ALU_MULH;
      3'b010:  return ALU_MULHSU;
      3'b011:  return ALU_MULHU;
      3'b100:  return ALU_DIV;
      3'b101:  return ALU_DIVU;
      3'b110:  return ALU_REM;
      default: return ALU_REMU;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_comb.sv
// Combinational RV32I/RV64I decoder: instruction word to ALU funct, register indices, immediate, class.
// DECODE_M_EXT_EN enables OP funct7=0000001 (MUL/DIV/REM); otherwise that encoding is illegal.
module decode_comb
  import decode_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic [31:0]                instr,
  output logic [ALU_FUNCT_WIDTH-1:0] alu_funct,
  output logic [4:0]                 rs1,
  output logic [4:0]                 rs2,
  output logic [4:0]                 rd,
  output logic [XLEN-1:0]            immed,
  output logic [3:0]                 op_class,
  output logic                       use_imm,
  output logic                       illegal
);

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [31:0]     imm_i32, imm_s32, imm_b32, imm_u32, imm_j32;
  logic [XLEN-1:0] shamt_imm;
  logic            bad;

  always_comb begin
    opcode  = instr[6:0];
    funct3  = instr[FUNCT3_LSB +: 3];
    funct7  = instr[FUNCT7_LSB +: 7];
    imm_i32 = {{20{instr[31]}}, instr[31:20]};
    imm_s32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    imm_b32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm_u32 = {instr[31:12], 12'b0};
    imm_j32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    shamt_imm = '0;
    shamt_imm[SHAMT_W-1:0] = instr[SHAMT_LSB +: SHAMT_W];

    alu_funct = ALU_ADD;
    rs1       = instr[RS1_LSB +: 5];
    rs2       = instr[RS2_LSB +: 5];
    rd        = instr[RD_LSB +: 5];
    immed     = '0;
    op_class  = OC_ILLEGAL;
    use_imm   = 1'b0;
    bad       = 1'b0;

    case (opcode)
      OPC_OP: begin
        op_class = OC_OP;
        case (funct7)
          FUNCT7_BASE: alu_funct = base_funct(funct3);
          FUNCT7_ALT: begin
            if (funct3 == 3'b000)      alu_funct = ALU_SUB;
            else if (funct3 == 3'b101) alu_funct = ALU_SRA;
            else                       bad = 1'b1;
          end
`ifdef DECODE_M_EXT_EN
          FUNCT7_M: alu_funct = m_funct(funct3);
`endif
          default: bad = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        op_class  = OC_OP_IMM;
        use_imm   = 1'b1;
        immed     = sext32(imm_i32);
        alu_funct = base_funct(funct3);
        // Bits above the shamt field must be clear; bit 30 alone picks SRAI over SRLI.
        if (funct3 == 3'b001) begin
          immed = shamt_imm;
          bad   = (instr[31:SHAMT_LSB+SHAMT_W] != '0);
        end else if (funct3 == 3'b101) begin
          immed     = shamt_imm;
          alu_funct = instr[30] ? ALU_SRA : ALU_SRL;
          bad       = ({instr[31], instr[29:SHAMT_LSB+SHAMT_W]} != '0);
        end
      end
      OPC_LOAD: begin
        op_class = OC_LOAD;
        use_imm  = 1'b1;
        immed    = sext32(imm_i32);
      end
      OPC_STORE: begin
        op_class = OC_STORE;
        use_imm  = 1'b1;
        immed    = sext32(imm_s32);
      end
      OPC_BRANCH: begin
        op_class = OC_BRANCH;
        immed    = sext32(imm_b32);
        case (funct3)
          3'b000, 3'b001: alu_funct = ALU_SUB;
          3'b100, 3'b101: alu_funct = ALU_SLT;
          3'b110, 3'b111: alu_funct = ALU_SLTU;
          default:        bad = 1'b1;
        endcase
      end
      OPC_LUI: begin
        op_class = OC_LUI;
        use_imm  = 1'b1;
        immed    = sext32(imm_u32);
      end
      OPC_AUIPC: begin
        op_class = OC_AUIPC;
        use_imm  = 1'b1;
        immed    = sext32(imm_u32);
      end
      OPC_JAL: begin
        op_class = OC_JAL;
        use_imm  = 1'b1;
        immed    = sext32(imm_j32);
      end
      OPC_JALR: begin
        op_class = OC_JALR;
        use_imm  = 1'b1;
        immed    = sext32(imm_i32);
      end
      OPC_SYSTEM: begin
        op_class = OC_SYSTEM;
        immed    = sext32(imm_i32);
      end
      default: bad = 1'b1;
    endcase

    // An illegal bundle must not write a register or look like an immediate op downstream.
    if (bad) begin
      alu_funct = ALU_ADD;
      rd        = 5'd0;
      use_imm   = 1'b0;
      immed     = '0;
    end
    illegal = bad;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with 2-entry skid: 1-cycle latency; in_ready is a flop, deasserted only when
// both entries are full. Flush empties both entries and drops a same-cycle accept. See decode_comb for DECODE_M_EXT_EN.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [XLEN-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [ALU_FUNCT_WIDTH-1:0] out_alu_funct,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [4:0]                 out_rd,
  output logic [XLEN-1:0]            out_immed,
  output logic [3:0]                 out_op_class,
  output logic                       out_use_imm,
  output logic                       out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0]            pc;
    logic [ALU_FUNCT_WIDTH-1:0] alu_funct;
    logic [4:0]                 rs1;
    logic [4:0]                 rs2;
    logic [4:0]                 rd;
    logic [XLEN-1:0]            immed;
    logic [3:0]                 op_class;
    logic                       use_imm;
    logic                       illegal;
  } bundle_t;

  logic [ALU_FUNCT_WIDTH-1:0] dec_alu_funct;
  logic [4:0]                 dec_rs1, dec_rs2, dec_rd;
  logic [XLEN-1:0]            dec_immed;
  logic [3:0]                 dec_op_class;
  logic                       dec_use_imm, dec_illegal;
  bundle_t                    dec;

  decode_comb #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_decode_comb (
    .instr     (in_instr),
    .alu_funct (dec_alu_funct),
    .rs1       (dec_rs1),
    .rs2       (dec_rs2),
    .rd        (dec_rd),
    .immed     (dec_immed),
    .op_class  (dec_op_class),
    .use_imm   (dec_use_imm),
    .illegal   (dec_illegal)
  );

  assign dec = '{pc: in_pc, alu_funct: dec_alu_funct, rs1: dec_rs1, rs2: dec_rs2, rd: dec_rd,
                 immed: dec_immed, op_class: dec_op_class, use_imm: dec_use_imm, illegal: dec_illegal};

  state_e  state_q, state_d;
  logic    in_ready_q, in_ready_d;
  bundle_t out_q, out_d;
  bundle_t skid_q, skid_d;
  logic    accept, consume;

  always_comb begin
    accept  = in_valid && in_ready_q;
    consume = (state_q != ST_EMPTY) && out_ready;
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          out_d   = dec;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && consume) begin
          out_d = dec;
        end else if (accept) begin
          skid_d  = dec;
          state_d = ST_FULL;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready_q is low here, so the only event is the skid entry advancing.
        if (consume) begin
          out_d   = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (flush) state_d = ST_EMPTY;
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = (state_q != ST_EMPTY);
  assign out_pc        = out_q.pc;
  assign out_alu_funct = out_q.alu_funct;
  assign out_rs1       = out_q.rs1;
  assign out_rs2       = out_q.rs2;
  assign out_rd        = out_q.rd;
  assign out_immed     = out_q.immed;
  assign out_op_class  = out_q.op_class;
  assign out_use_imm   = out_q.use_imm;
  assign out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed cases plus randomized traffic against a queue-based reference model.
// Expected bundles come from a behavioural decoder written from the ISA rules with integer arithmetic.
module tb_decode_stage;
  import decode_stage_pkg::*;

  localparam int XLEN = 32;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       flush;
  logic                       in_valid;
  logic                       in_ready;
  logic [31:0]                in_instr;
  logic [XLEN-1:0]            in_pc;
  logic                       out_valid;
  logic                       out_ready;
  logic [XLEN-1:0]            out_pc;
  logic [ALU_FUNCT_WIDTH-1:0] out_alu_funct;
  logic [4:0]                 out_rs1, out_rs2, out_rd;
  logic [XLEN-1:0]            out_immed;
  logic [3:0]                 out_op_class;
  logic                       out_use_imm;
  logic                       out_illegal;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(XLEN)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_alu_funct (out_alu_funct),
    .out_rs1       (out_rs1),
    .out_rs2       (out_rs2),
    .out_rd        (out_rd),
    .out_immed     (out_immed),
    .out_op_class  (out_op_class),
    .out_use_imm   (out_use_imm),
    .out_illegal   (out_illegal)
  );

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      alu_funct;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] immed;
    logic [3:0]      op_class;
    logic            use_imm;
    logic            illegal;
  } bnd_t;

  localparam logic [4:0] OP_TBL [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
  localparam logic [4:0] M_TBL  [8] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  localparam logic [4:0] BR_TBL [8] = '{ALU_SUB, ALU_SUB, ALU_ADD, ALU_ADD, ALU_SLT, ALU_SLT, ALU_SLTU, ALU_SLTU};
  localparam logic [6:0] OPC_TBL [10] = '{OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                                          OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_SYSTEM};

  int   n_chk  = 0;
  int   n_fail = 0;
  bnd_t q[$];

  task automatic chk_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic bnd_t ref_decode(input logic [31:0] ins, input logic [XLEN-1:0] pc);
    bnd_t        b;
    int          s;
    int unsigned u;
    int          f3, f7, imm;
    logic        ill;
    s   = $signed(ins);
    u   = ins;
    f3  = int'((u >> 12) & 7);
    f7  = int'((u >> 25) & 127);
    b   = '0;
    ill = 1'b0;
    imm = 0;
    b.pc = pc;
    b.rs1 = ins[19:15];
    b.rs2 = ins[24:20];
    b.rd  = ins[11:7];
    b.alu_funct = ALU_ADD;
    case (ins[6:0])
      OPC_OP: begin
        b.op_class = OC_OP;
        if (f7 == 0) b.alu_funct = OP_TBL[f3];
        else if (f7 == 32 && f3 == 0) b.alu_funct = ALU_SUB;
        else if (f7 == 32 && f3 == 5) b.alu_funct = ALU_SRA;
`ifdef DECODE_M_EXT_EN
        else if (f7 == 1) b.alu_funct = M_TBL[f3];
`endif
        else ill = 1'b1;
      end
      OPC_OP_IMM: begin
        b.op_class = OC_OP_IMM; b.use_imm = 1'b1;
        b.alu_funct = OP_TBL[f3];
        imm = s >>> 20;
        if (f3 == 1) begin
          imm = int'((u >> 20) & 31);
          ill = ((u >> 25) != 0);
        end else if (f3 == 5) begin
          imm = int'((u >> 20) & 31);
          ill = (((u >> 25) & 32'h5F) != 0);
          b.alu_funct = ((u >> 30) & 1) != 0 ? ALU_SRA : ALU_SRL;
        end
      end
      OPC_LOAD:  begin b.op_class = OC_LOAD;  b.use_imm = 1'b1; imm = s >>> 20; end
      OPC_JALR:  begin b.op_class = OC_JALR;  b.use_imm = 1'b1; imm = s >>> 20; end
      OPC_STORE: begin
        b.op_class = OC_STORE; b.use_imm = 1'b1;
        imm = ((s >>> 25) * 32) + int'((u >> 7) & 31);
      end
      OPC_BRANCH: begin
        b.op_class = OC_BRANCH;
        b.alu_funct = BR_TBL[f3];
        ill = (f3 == 2 || f3 == 3);
        imm = ((s >>> 31) * 4096) + int'(((u >> 7) & 1) << 11) + int'(((u >> 25) & 63) << 5)
              + int'(((u >> 8) & 15) << 1);
      end
      OPC_LUI:   begin b.op_class = OC_LUI;   b.use_imm = 1'b1; imm = int'(u & 32'hFFFFF000); end
      OPC_AUIPC: begin b.op_class = OC_AUIPC; b.use_imm = 1'b1; imm = int'(u & 32'hFFFFF000); end
      OPC_JAL: begin
        b.op_class = OC_JAL; b.use_imm = 1'b1;
        imm = ((s >>> 31) * 1048576) + int'(((u >> 12) & 255) << 12) + int'(((u >> 20) & 1) << 11)
              + int'(((u >> 21) & 1023) << 1);
      end
      OPC_SYSTEM: b.op_class = OC_SYSTEM;
      default: ill = 1'b1;
    endcase
    b.immed = XLEN'(imm);
    if (ill) begin
      b.illegal = 1'b1; b.alu_funct = ALU_ADD; b.rd = 5'd0; b.use_imm = 1'b0;
    end
    return b;
  endfunction

  function automatic bnd_t get_out();
    bnd_t b;
    b.pc = out_pc; b.alu_funct = out_alu_funct; b.rs1 = out_rs1; b.rs2 = out_rs2; b.rd = out_rd;
    b.immed = out_immed; b.op_class = out_op_class; b.use_imm = out_use_imm; b.illegal = out_illegal;
    return b;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    int          pick;
    ins  = $urandom;
    pick = $urandom_range(0, 11);
    if (pick < 10) ins[6:0] = OPC_TBL[pick];
    case ($urandom_range(0, 4))
      0: ins[31:25] = 7'h00;
      1: ins[31:25] = 7'h20;
      2: ins[31:25] = 7'h01;
      default: ;
    endcase
    return ins;
  endfunction

  // One clock of traffic: drive after the edge, check and advance the model before the next edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [XLEN-1:0] pc,
                      input logic ordy, input logic fl);
    bnd_t e, a;
    logic exp_rdy, acc, cons;
    @(posedge clk); #1;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    @(negedge clk);
    exp_rdy = (q.size() < 2);
    chk_eq("in_ready", 128'(in_ready), 128'(exp_rdy));
    chk_eq("out_valid", 128'(out_valid), 128'(q.size() > 0));
    if (q.size() > 0) begin
      e = q[0];
      a = get_out();
      // Immediate/class fields the ISA leaves undefined for these bundles are not compared.
      if (e.illegal || e.op_class == OC_OP || e.op_class == OC_SYSTEM) begin
        e.immed = '0; a.immed = '0;
      end
      if (e.illegal) begin
        e.op_class = '0; a.op_class = '0;
      end
      chk_eq("bundle", 128'(a), 128'(e));
    end
    acc  = v && exp_rdy;
    cons = (q.size() > 0) && ordy;
    if (fl) q.delete();
    else begin
      if (cons) void'(q.pop_front());
      if (acc) q.push_back(ref_decode(ins, pc));
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk_eq({tag, "_valid"}, 128'(out_valid), 128'(0));
    chk_eq({tag, "_ready"}, 128'(in_ready), 128'(1));
    chk_eq({tag, "_data"}, 128'(get_out()), 128'(0));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("reset");
    step(0, 32'h0, 32'h0, 1, 0);

    // ADDI x1,x2,-1
    step(1, 32'hFFF10093, 32'h100, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    chk_eq("addi_rd", 128'(out_rd), 128'(1));
    chk_eq("addi_rs1", 128'(out_rs1), 128'(2));
    chk_eq("addi_imm", 128'(out_immed), 128'(32'hFFFFFFFF));
    chk_eq("addi_funct", 128'(out_alu_funct), 128'(ALU_ADD));
    chk_eq("addi_use_imm", 128'(out_use_imm), 128'(1));

    // SRAI x1,x1,3 then BEQ x0,x0,-4 back to back
    step(1, 32'h4030D093, 32'h104, 1, 0);
    step(1, 32'hFE000EE3, 32'h108, 1, 0);
    chk_eq("srai_funct", 128'(out_alu_funct), 128'(ALU_SRA));
    chk_eq("srai_imm", 128'(out_immed), 128'(3));
    step(0, 32'h0, 32'h0, 1, 0);
    chk_eq("beq_funct", 128'(out_alu_funct), 128'(ALU_SUB));
    chk_eq("beq_imm", 128'(out_immed), 128'(32'hFFFFFFFC));
    chk_eq("beq_use_imm", 128'(out_use_imm), 128'(0));

    // Backpressure: three offered with out_ready low, then released
    step(1, 32'h00100093, 32'h200, 0, 0);
    step(1, 32'h00200113, 32'h204, 0, 0);
    step(1, 32'h00300193, 32'h208, 0, 0);
    chk_eq("bp_in_ready", 128'(in_ready), 128'(0));
    step(1, 32'h00300193, 32'h208, 1, 0);
    step(1, 32'h00300193, 32'h208, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);

    // Flush while FULL with in_valid high, then flush while accepting from ONE
    step(1, 32'h00400213, 32'h300, 0, 0);
    step(1, 32'h00500293, 32'h304, 0, 0);
    step(1, 32'h00600313, 32'h308, 0, 1);
    step(0, 32'h0, 32'h0, 1, 0);
    chk_eq("flush_valid", 128'(out_valid), 128'(0));
    chk_eq("flush_ready", 128'(in_ready), 128'(1));
    step(1, 32'h00700393, 32'h30C, 0, 0);
    step(1, 32'h00800413, 32'h310, 0, 1);
    repeat (3) step(0, 32'h0, 32'h0, 1, 0);

    // All-zero word and MUL
    step(1, 32'h00000000, 32'h400, 1, 0);
    step(1, 32'h02000033, 32'h404, 1, 0);
    chk_eq("zero_illegal", 128'(out_illegal), 128'(1));
    step(0, 32'h0, 32'h0, 1, 0);
`ifdef DECODE_M_EXT_EN
    chk_eq("mul_illegal", 128'(out_illegal), 128'(0));
    chk_eq("mul_funct", 128'(out_alu_funct), 128'(ALU_MUL));
`else
    chk_eq("mul_illegal", 128'(out_illegal), 128'(1));
    chk_eq("mul_funct", 128'(out_alu_funct), 128'(ALU_ADD));
`endif

    // Reset while holding two bundles and offering a third
    step(1, 32'h00900493, 32'h500, 0, 0);
    step(1, 32'h00A00513, 32'h504, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b1; in_instr = 32'h00B00593; out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    q.delete();
    check_reset_state("mid_reset");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 7), rand_instr(), XLEN'($urandom),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 39) == 0));
    end
    repeat (4) step(0, 32'h0, 32'h0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
